// File: rtl/gpio_input_irq.sv
// GPIO input monitor: per-pin two-flop sync, debounce, selectable edge detection
// into sticky W1C status, and a single level interrupt on the CPU register bus.
module gpio_input_irq #(
    parameter int unsigned ADDR_WIDTH      = 4,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned GPIO_WIDTH      = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_sel,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata,
    input  logic [GPIO_WIDTH-1:0] i_gpio_in,
    output logic                  o_irq
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STATE  = ADDR_WIDTH'(4'h0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_EN     = ADDR_WIDTH'(4'h4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_EDGE   = ADDR_WIDTH'(4'h8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(4'hC);

    logic [GPIO_WIDTH-1:0] sync1_q, sync1_d;
    logic [GPIO_WIDTH-1:0] sync2_q, sync2_d;
    logic [GPIO_WIDTH-1:0] state_q, state_d;
    logic [GPIO_WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [GPIO_WIDTH-1:0] irq_en_q, irq_en_d;
    logic [GPIO_WIDTH-1:0] edge_sel_q, edge_sel_d;
    logic [GPIO_WIDTH-1:0] status_q, status_d;

    logic [GPIO_WIDTH-1:0] wdata_g;
    logic [GPIO_WIDTH-1:0] rise_c, fall_c, event_c, clr_c;
    logic                  wr_en;
    logic                  unused_wdata;

    assign wr_en        = i_sel & i_we;
    assign wdata_g      = i_wdata[GPIO_WIDTH-1:0];
    assign unused_wdata = ^i_wdata;

    // Synchroniser and per-pin debounce counter
    always_comb begin
        sync1_d = i_gpio_in;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < int'(GPIO_WIDTH); i++) begin
            if (sync2_q[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                state_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Edge events and register writes; a new event beats a same-cycle W1C
    always_comb begin
        rise_c     = state_d & ~state_q;
        fall_c     = ~state_d & state_q;
        event_c    = (edge_sel_q & rise_c) | (~edge_sel_q & fall_c);
        clr_c      = '0;
        irq_en_d   = irq_en_q;
        edge_sel_d = edge_sel_q;
        if (wr_en) begin
            if (i_addr == ADDR_EN)     irq_en_d   = wdata_g;
            if (i_addr == ADDR_EDGE)   edge_sel_d = wdata_g;
            if (i_addr == ADDR_STATUS) clr_c      = wdata_g;
        end
        status_d = (status_q & ~clr_c) | event_c;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            state_q    <= '0;
            cnt_q      <= '0;
            irq_en_q   <= '0;
            edge_sel_q <= '0;
            status_q   <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            irq_en_q   <= irq_en_d;
            edge_sel_q <= edge_sel_d;
            status_q   <= status_d;
        end
    end

    // Combinational read mux, zero outside a read cycle
    always_comb begin
        o_rdata = '0;
        if (i_sel && !i_we) begin
            case (i_addr)
                ADDR_STATE:  o_rdata = DATA_WIDTH'(state_q);
                ADDR_EN:     o_rdata = DATA_WIDTH'(irq_en_q);
                ADDR_EDGE:   o_rdata = DATA_WIDTH'(edge_sel_q);
                ADDR_STATUS: o_rdata = DATA_WIDTH'(status_q);
                default:     o_rdata = '0;
            endcase
        end
    end

    assign o_irq = |(status_q & irq_en_q);

endmodule

// File: tb/tb_gpio_input_irq.sv
// Bench for gpio_input_irq: directed scenarios plus random pin/bus traffic
// compared against a windowed reference model of the debounce rule.
module tb_gpio_input_irq;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned GW = 4;
    localparam int unsigned DB = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          i_sel;
    logic          i_we;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_wdata;
    logic [DW-1:0] o_rdata;
    logic [GW-1:0] i_gpio_in;
    logic          o_irq;

    int n_pass = 0;
    int n_total = 0;

    gpio_input_irq #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GPIO_WIDTH(GW), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .resetn(resetn), .i_sel(i_sel), .i_we(i_we), .i_addr(i_addr),
        .i_wdata(i_wdata), .o_rdata(o_rdata), .i_gpio_in(i_gpio_in), .o_irq(o_irq)
    );

    always #5 clk = ~clk;

    // Reference model: a level is accepted once the synchronised pin has shown
    // the opposite value on each of the last DB clocks.
    logic [GW-1:0] hist [0:DB];
    logic [GW-1:0] m_state, m_en, m_sel, m_status;

    always @(posedge clk or negedge resetn) begin
        logic [GW-1:0] nxt, ev, clr;
        logic          all_diff;
        if (!resetn) begin
            for (int j = 0; j <= int'(DB); j++) hist[j] = '0;
            m_state = '0; m_en = '0; m_sel = '0; m_status = '0;
        end else begin
            nxt = m_state;
            for (int p = 0; p < int'(GW); p++) begin
                all_diff = 1'b1;
                for (int j = 1; j <= int'(DB); j++)
                    if (hist[j][p] == m_state[p]) all_diff = 1'b0;
                if (all_diff) nxt[p] = ~m_state[p];
            end
            ev = '0;
            for (int p = 0; p < int'(GW); p++)
                if (nxt[p] != m_state[p] && nxt[p] == m_sel[p]) ev[p] = 1'b1;
            clr = '0;
            if (i_sel && i_we) begin
                if (i_addr == 4'h4) m_en = i_wdata[GW-1:0];
                if (i_addr == 4'h8) m_sel = i_wdata[GW-1:0];
                if (i_addr == 4'hC) clr = i_wdata[GW-1:0];
            end
            m_status = (m_status & ~clr) | ev;
            m_state  = nxt;
            for (int j = int'(DB); j >= 1; j--) hist[j] = hist[j-1];
            hist[0] = i_gpio_in;
        end
    end

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        case (a)
            4'h0:    return DW'(m_state);
            4'h4:    return DW'(m_en);
            4'h8:    return DW'(m_sel);
            4'hC:    return DW'(m_status);
            default: return '0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        i_sel = 1'b1; i_we = 1'b1; i_addr = a; i_wdata = d;
        @(negedge clk);
        i_sel = 1'b0; i_we = 1'b0; i_wdata = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
        i_sel = 1'b1; i_we = 1'b0; i_addr = a;
        #1;
        d = o_rdata;
        i_sel = 1'b0;
    endtask

    // Reads a register and checks it against both a directed value and the model
    task automatic rd_chk(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        logic [DW-1:0] d;
        rd(a, d);
        check(tag, d, exp);
        check({tag, "_model"}, d, model_rd(a));
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [GW-1:0] flip;
        logic [AW-1:0] addrs [0:4];
        addrs[0] = 4'h0; addrs[1] = 4'h4; addrs[2] = 4'h8; addrs[3] = 4'hC; addrs[4] = 4'h6;

        resetn = 1'b0; i_sel = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0; i_gpio_in = '0;
        tick(3);
        resetn = 1'b1;
        tick(1);

        // Reset state
        rd_chk(4'h0, 32'h0, "rst_state");
        rd_chk(4'h4, 32'h0, "rst_en");
        rd_chk(4'h8, 32'h0, "rst_edge");
        rd_chk(4'hC, 32'h0, "rst_status");
        check("rst_irq", 32'(o_irq), 32'h0);

        // Rising edge on pin0 with exact debounce latency
        wr(4'h4, 32'hFFFF_FFF1);
        wr(4'h8, 32'h1);
        rd_chk(4'h4, 32'h1, "en_upper_ignored");
        i_gpio_in = 4'b0001;
        tick(5);
        rd_chk(4'h0, 32'h0, "lat_before");
        check("irq_before", 32'(o_irq), 32'h0);
        tick(1);
        rd_chk(4'h0, 32'h1, "lat_at");
        rd_chk(4'hC, 32'h1, "rise_status");
        check("rise_irq", 32'(o_irq), 32'h1);
        wr(4'hC, 32'h1);
        rd_chk(4'hC, 32'h0, "w1c_status");
        check("w1c_irq", 32'(o_irq), 32'h0);

        // Pin1 glitches: 3 cycles rejected, 4 cycles accepted
        i_gpio_in = 4'b0011;
        tick(3);
        i_gpio_in = 4'b0001;
        tick(8);
        rd_chk(4'h0, 32'h1, "glitch3_state");
        rd_chk(4'hC, 32'h0, "glitch3_status");
        i_gpio_in = 4'b0011;
        tick(4);
        i_gpio_in = 4'b0001;
        tick(2);
        rd_chk(4'h0, 32'h3, "glitch4_state");
        tick(8);
        rd_chk(4'h0, 32'h1, "glitch4_back");

        // Pin2 falling-edge select with interrupt disabled
        wr(4'h8, 32'h1);
        wr(4'h4, 32'h0);
        wr(4'hC, 32'hF);
        rd_chk(4'hC, 32'h0, "fall_clr");
        i_gpio_in = 4'b0101;
        tick(8);
        rd_chk(4'h0, 32'h5, "p2_high");
        rd_chk(4'hC, 32'h0, "p2_rise_nostat");
        i_gpio_in = 4'b0001;
        tick(8);
        rd_chk(4'hC, 32'h4, "p2_fall_stat");
        check("p2_irq_dis", 32'(o_irq), 32'h0);
        wr(4'h4, 32'h4);
        check("p2_irq_en", 32'(o_irq), 32'h1);
        wr(4'h4, 32'h0);
        check("p2_irq_dis2", 32'(o_irq), 32'h0);
        wr(4'h8, 32'h0);
        rd_chk(4'hC, 32'h4, "edgesel_nochange");
        wr(4'h8, 32'h1);
        wr(4'hC, 32'h4);

        // W1C colliding with a new event on the same edge: set wins
        i_gpio_in = 4'b0000;
        tick(8);
        rd_chk(4'h0, 32'h0, "p0_low");
        i_gpio_in = 4'b0001;
        tick(5);
        wr(4'hC, 32'h1);
        rd_chk(4'hC, 32'h1, "set_beats_w1c");
        wr(4'hC, 32'h1);
        rd_chk(4'hC, 32'h0, "w1c_after");

        // Random pin and bus traffic against the model
        for (int c = 0; c < 400; c++) begin
            flip = '0;
            for (int p = 0; p < int'(GW); p++)
                if ($urandom_range(0, 5) == 0) flip[p] = 1'b1;
            i_gpio_in = i_gpio_in ^ flip;
            check("rnd_irq", 32'(o_irq), 32'(|(m_status & m_en)));
            if ($urandom_range(0, 7) == 0) begin
                wr(addrs[$urandom_range(0, 4)], $urandom);
            end else begin
                i_addr = addrs[$urandom_range(0, 4)];
                rd(i_addr, d);
                check("rnd_rd", d, model_rd(i_addr));
                tick(1);
            end
        end

        // Bus corner cases
        i_gpio_in = 4'b0000;
        tick(10);
        wr(4'h4, 32'h0);
        wr(4'hC, 32'hF);
        i_sel = 1'b0; i_we = 1'b0; i_addr = 4'h0;
        #1;
        check("nosel_rdata", o_rdata, 32'h0);
        i_sel = 1'b1; i_we = 1'b1; i_addr = 4'h4;
        #1;
        check("wr_rdata", o_rdata, 32'h0);
        i_sel = 1'b0; i_we = 1'b0;
        wr(4'h8, 32'hA);
        rd_chk(4'h6, 32'h0, "unmapped_rd");
        wr(4'h0, 32'hF);
        rd_chk(4'h0, 32'h0, "state_ro");
        wr(4'h6, 32'hF);
        rd_chk(4'h8, 32'hA, "unmapped_wr");

        // Reset asserted mid-debounce
        wr(4'h4, 32'hF);
        i_gpio_in = 4'b1111;
        tick(4);
        resetn = 1'b0;
        i_gpio_in = 4'b0000;
        #1;
        check("mid_rst_irq", 32'(o_irq), 32'h0);
        rd_chk(4'h4, 32'h0, "mid_rst_en");
        rd_chk(4'h0, 32'h0, "mid_rst_state");
        tick(2);
        resetn = 1'b1;
        tick(10);
        rd_chk(4'h0, 32'h0, "post_rst_state");
        rd_chk(4'hC, 32'h0, "post_rst_status");
        check("post_rst_irq", 32'(o_irq), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gpio_input_irq.md
Name: gpio_input_irq

Overview:
- Input-side companion to the GPIO control block. Consumes the raw pin states it reads back from gpio_pins.
- Per pin: two-flop synchronisation, debounce, then rising/falling edge detection into sticky interrupt status.
- Drives one level interrupt to the SoC interrupt controller.
- Sits on the same CPU register bus (i_sel/i_we/i_addr/i_wdata/o_rdata) as the GPIO control block.

Parameters:
- ADDR_WIDTH, 4, register offset width
- DATA_WIDTH, 32, bus data width
- GPIO_WIDTH, 4, number of monitored pins (1..DATA_WIDTH)
- DEBOUNCE_CYCLES, 4, consecutive stable clocks required to accept a level change (>=1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- resetn  input  1  asynchronous active-low reset
- i_sel  input  1  chip select
- i_we  input  1  write enable (1 write, 0 read)
- i_addr  input  ADDR_WIDTH  register offset
- i_wdata  input  DATA_WIDTH  write data
- o_rdata  output  DATA_WIDTH  read data, combinational
- i_gpio_in  input  GPIO_WIDTH  raw asynchronous pin levels
- o_irq  output  1  level interrupt, active high

Behaviour:
- Reset (async, resetn=0): sync flops, debounced state, per-pin counters, IRQ_EN, EDGE_SEL and IRQ_STATUS all go to 0. o_irq=0 and o_rdata=0.
- Register map (full i_addr compare):
  - 0x0 STATE: RO, debounced levels.
  - 0x4 IRQ_EN: RW.
  - 0x8 EDGE_SEL: RW. Bit=1 selects rising edge, bit=0 selects falling edge.
  - 0xC IRQ_STATUS: RO for read, write-1-to-clear.
  - Writes to STATE or unmapped offsets are ignored.
- Write path: on a clk edge with i_sel=1 and i_we=1, the target register takes i_wdata[GPIO_WIDTH-1:0]. Upper bits are ignored.
- Read path (combinational): with i_sel=1 and i_we=0, o_rdata = zero-extended register. Unmapped offsets read 0. With i_sel=0 or i_we=1, o_rdata=0 (no latch).
- Synchroniser: sync1<=i_gpio_in, sync2<=sync1, per bit.
- Debounce, per pin, with counter width max(1,$clog2(DEBOUNCE_CYCLES)):
  - sync2==state: cnt<=0.
  - sync2!=state and cnt==DEBOUNCE_CYCLES-1: state<=sync2, cnt<=0.
  - Otherwise: cnt<=cnt+1.
  - Any return to the current state before acceptance restarts the count. Glitches shorter than DEBOUNCE_CYCLES synchronised clocks are rejected.
- Latency: an input change stable from before edge k updates state at edge k+1+DEBOUNCE_CYCLES.
- Edge event, per pin, registered:
  - rise = state_next & ~state.
  - fall = ~state_next & state.
  - event = EDGE_SEL ? rise : fall.
  - An event sets its IRQ_STATUS bit on the same edge that state updates.
- Status bits are set regardless of IRQ_EN and stay sticky until cleared.
- Set and W1C of the same bit on the same edge: set wins, bit stays 1.
- o_irq = |(IRQ_STATUS & IRQ_EN), decoded from registers only (glitch-free).
  - Enabling a pin whose status is already 1 raises o_irq the cycle after the write.
  - Disabling it drops o_irq the cycle after the write.
- Changing EDGE_SEL does not create or clear status; it only affects later events.
- Post-reset: a pin held high produces a rising event after debounce. Software clears IRQ_STATUS before enabling.
- Reset mid-debounce: counter and state return to 0 immediately; no event is generated.

Test Plan:
1. Reset with i_gpio_in=4'b0000, DEBOUNCE_CYCLES=4 -> all reads 0, o_irq=0. Read 0x8 -> 0x00000000.
2. Write IRQ_EN=0x1, EDGE_SEL=0x1, then drive pin0 high at edge k -> STATE reads 0x1 from edge k+5, IRQ_STATUS=0x1, o_irq=1. Write 0xC=0x1 -> status 0, o_irq=0 next cycle.
3. Pin1 glitch high for 3 synchronised cycles, DEBOUNCE_CYCLES=4 -> STATE bit1 stays 0, no status. Glitch of 4 cycles -> bit1 becomes 1.
4. EDGE_SEL bit2=0 (falling), IRQ_EN=0: pin2 rises then falls, each debounced -> status bit2 set only after the fall, o_irq=0. Write IRQ_EN=0x4 -> o_irq=1 next cycle.
5. W1C of bit0 issued on the same edge a new pin0 event sets it -> IRQ_STATUS bit0 remains 1.
6. Read with i_sel=0, and read of offset 0x6 -> o_rdata=0. Write 0x0=0xF -> STATE unchanged. Assert resetn=0 mid-debounce -> state/cnt/status 0 asynchronously.
